pcm_serial_tx: RTL and testbench
================================

# pcm_serial_tx

Output stage placed directly downstream of the delta-sigma decimation filter. It accepts the filter's decimated PCM samples as single-cycle `in_valid` pulses and buffers them in a small synchronous FIFO. It shifts each sample out MSB-first on a three-wire serial link (`sclk`, `sdata`, `fs`) so an off-chip MCU or logic analyser can capture them through the dedicated output pins. It also reports buffer fill and a sticky overflow flag.

## Interface
Parameters:
- `DATA_W`, 16: PCM sample width in bits. Must be ≥ 2.
- `DEPTH`, 4: FIFO depth in words. Must be a power of two, ≥ 2.
- `SCLK_DIV`, 4: `clk` cycles per `sclk` period. Must be even, ≥ 2. Half-period is H = `SCLK_DIV`/2.

Ports:
- `clk`  in  1  System clock. Single clock domain.
- `rst`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  One-cycle strobe: `in_data` holds a new decimated sample.
- `in_data`  in  DATA_W  Signed two's-complement sample. Passed through unmodified.
- `clr_ovf`  in  1  Synchronous clear of `overflow`.
- `sclk`  out  1  Serial clock. Idles low.
- `sdata`  out  1  Serial data. Changes on the falling edge of `sclk`; the receiver samples on the rising edge.
- `fs`  out  1  Frame sync. High for the MSB bit period of each word.
- `busy`  out  1  High while a word is being shifted.
- `level`  out  $clog2(DEPTH+1)  Number of FIFO entries.
- `overflow`  out  1  Sticky. Set when a sample is dropped because the FIFO is full.

## Operation
- **Reset values.** While `rst` is high, every output is 0: `sclk`=0, `sdata`=0, `fs`=0, `busy`=0, `level`=0, `overflow`=0. Reset also empties the FIFO and returns the FSM to IDLE. A reset asserted mid-word aborts the word immediately, with no partial completion. All outputs are registered.
- **FIFO write.** A write happens when `in_valid`=1 and the FIFO is not full.
  - If `in_valid`=1 while the FIFO is full, the sample is dropped and `overflow` is set on the next cycle.
  - Exception: if a pop occurs in the same cycle as a write to a full FIFO, the write is accepted and `level` is unchanged.
- **Overflow flag.** If `clr_ovf` and a new drop occur in the same cycle, the set wins.
- **FSM states:**
  - IDLE: `busy`=0, `sclk`=0, `sdata`=0, `fs`=0.
    - If `level`>0, the FSM pops the head word into the shift register and moves to SHIFT.
  - SHIFT: uses a bit counter b from DATA_W-1 down to 0 and a phase counter p from 0 to SCLK_DIV-1.
    - `sdata` = word[b].
    - `sclk` = 1 when p ≥ H.
    - `fs` = 1 when b = DATA_W-1.
    - In the last cycle of bit 0:
      - If `level`>0, pop the next word and stay in SHIFT. The next word starts with no gap.
      - Otherwise return to IDLE.
- **Data path.** There is no arithmetic on the sample data. Bits are emitted in order DATA_W-1 down to 0.
- **Throughput.** Sustained operation requires DATA_W·SCLK_DIV ≤ the decimation ratio in `clk` cycles. Exceeding this is allowed; the only consequence is dropped samples and `overflow`.

## Timing
- **Write into an empty, idle block.**
  - Write at cycle T; `level`=1 at T+1.
  - The FSM pops at T+1.
  - At T+2: `busy`=1, `fs`=1, `sdata`=MSB, `sclk`=0.
  - First `sclk` rising edge is at T+2+H.
- **Word length.** A word occupies exactly DATA_W·SCLK_DIV cycles of `busy`=1. Each bit is held for SCLK_DIV cycles.
- **Back-to-back words.** `fs` rises again exactly DATA_W·SCLK_DIV cycles after the previous word's `fs` rise.
- **End of transfer.** After the last word, `busy`, `sclk`, `sdata` and `fs` all return to 0 on the cycle after bit 0 completes.
- **`level` timing.** `level` updates one cycle after the push or pop that changes it.

## Structure
- Shared package `dsm_pkg` holds:
  - `PCM_W` (=16), the default for `DATA_W`, shared with the decimation filter's output width.
  - The FSM state enum `tx_state_t` {IDLE, SHIFT}.
- Sub-module `pcm_sample_fifo` is a synchronous single-clock FIFO.
  - Pointers carry an extra wrap bit for full/empty detection.
  - It outputs `full`, `empty` and `level`, and is reusable by other stages.
- The top level contains the FSM, the shift register and the phase/bit counters.

## Test plan
All scenarios use `DATA_W`=16, `DEPTH`=4, `SCLK_DIV`=4.
- **Reset mid-word.** Write 16'hA5C3, wait 20 cycles, hold `rst` 1 cycle. Required: all outputs 0 on the next cycle; no further `sclk` edges; `level`=0.
- **Single word.** Write 16'hA5C3 into an idle block. Required: `fs` high for cycles 2–5 after the write; 16 rising `sclk` edges capture 1010_0101_1100_0011; `busy` drops at cycle 66.
- **Back-to-back.** Write 16'h8001 then 16'h7FFF, 1 cycle apart. Required: the second `fs` rise is exactly 64 cycles after the first; no idle gap; both words captured correctly.
- **Overflow.** While the first word shifts, write 6 samples at 1-cycle spacing. Required: `level` peaks at 4; `overflow`=1; exactly 5 words (1 in flight + 4 queued) are emitted, in order. Then pulse `clr_ovf`: `overflow`=0.
- **Pop with write when full.** With the FIFO full, apply a write in the same cycle as the end-of-word pop. Required: the write is accepted, `level` stays 4, `overflow` stays 0.
- **Set beats clear.** Assert `clr_ovf` in the same cycle as a dropped write. Required: `overflow`=1 afterwards.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma output path.
package dsm_pkg;

    // Decimation filter output width, default PCM sample width downstream.
    localparam int unsigned PCM_W = 16;

    // Serial transmitter states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/pcm_serial_tx_if.sv
// Sample input, control and serial output bundle of pcm_serial_tx.
interface pcm_serial_tx_if
    import dsm_pkg::*;
#(
    parameter int unsigned DATA_W = PCM_W,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              clr_ovf;
    logic              sclk;
    logic              sdata;
    logic              fs;
    logic              busy;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    // Sample source / observer side.
    modport master (
        output in_valid, in_data, clr_ovf,
        input  sclk, sdata, fs, busy, level, overflow
    );

    // Transmitter side.
    modport slave (
        input  in_valid, in_data, clr_ovf,
        output sclk, sdata, fs, busy, level, overflow
    );

endinterface

// File: rtl/pcm_sample_fifo.sv
// Synchronous single-clock FIFO with wrap-bit pointers and a registered fill count.
module pcm_sample_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Full when the slot indices match but the wrap bits differ.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign level    = count;

    // Pointer and fill-count update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pcm_serial_tx.sv
// Buffers decimated PCM samples and shifts them out MSB-first on sclk/sdata/fs.
module pcm_serial_tx
    import dsm_pkg::*;
#(
    parameter int unsigned DATA_W   = PCM_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    pcm_serial_tx_if.slave bus
);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned PH_W  = $clog2(SCLK_DIV);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned H     = SCLK_DIV / 2;

    tx_state_t         state, state_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [PH_W-1:0]   ph_cnt, ph_n;
    logic [DATA_W-1:0] shreg, sh_n;

    logic              sclk_q, sdata_q, fs_q, busy_q, ovf_q;
    logic              sclk_n, sdata_n, fs_n, busy_n;

    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [LVL_W-1:0]  fifo_level;

    // A push into a full FIFO is only accepted when the same cycle pops.
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    pcm_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // Next-state, counters and next output values (outputs are registered from these).
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        ph_n    = ph_cnt;
        sh_n    = shreg;
        pop     = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SHIFT;
                    sh_n    = head;
                    bit_n   = BIT_W'(DATA_W - 1);
                    ph_n    = '0;
                end
            end
            SHIFT: begin
                if (ph_cnt == PH_W'(SCLK_DIV - 1)) begin
                    ph_n = '0;
                    if (bit_cnt == '0) begin
                        if (!empty) begin
                            pop   = 1'b1;
                            sh_n  = head;
                            bit_n = BIT_W'(DATA_W - 1);
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt - BIT_W'(1);
                    end
                end else begin
                    ph_n = ph_cnt + PH_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n == SHIFT);
        sdata_n = busy_n && sh_n[bit_n];
        sclk_n  = busy_n && (ph_n >= PH_W'(H));
        fs_n    = busy_n && (bit_n == BIT_W'(DATA_W - 1));
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            ph_cnt  <= '0;
            shreg   <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            ph_cnt  <= ph_n;
            shreg   <= sh_n;
            sclk_q  <= sclk_n;
            sdata_q <= sdata_n;
            fs_q    <= fs_n;
            busy_q  <= busy_n;
            // A new drop takes priority over a clear in the same cycle.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.sdata    = sdata_q;
    assign bus.fs       = fs_q;
    assign bus.busy     = busy_q;
    assign bus.level    = fifo_level;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Self-checking bench for pcm_serial_tx: word-level reference model plus directed scenarios.
module tb_pcm_serial_tx;

    localparam int W        = 16;
    localparam int DEP      = 4;
    localparam int D        = 4;
    localparam int H        = D / 2;
    localparam int WORD_CYC = W * D;
    localparam int TR       = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pcm_serial_tx_if #(.DATA_W(W), .DEPTH(DEP)) bus ();

    pcm_serial_tx #(
        .DATA_W   (W),
        .DEPTH    (DEP),
        .SCLK_DIV (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queue of buffered words, the word on the wire and its elapsed cycles.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_cur;
    bit           m_act;
    int           m_k;
    bit           m_ovf;
    bit           m_drop;
    bit           m_pop;

    // Observation records.
    bit           fs_tr   [TR];
    bit           busy_tr [TR];
    bit           sclk_tr [TR];
    int           lvl_tr  [TR];
    logic [W-1:0] cap_q[$];
    int           fs_rise[$];
    logic [W-1:0] cap;
    int           cap_n    = 0;
    int           rise_cnt = 0;
    int           lvl_max  = 0;
    logic         sclk_prev = 1'b0;
    logic         fs_prev   = 1'b0;
    int           e_bi;
    logic         e_sd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle write; leaves the bench at the following falling edge.
    task automatic wr(input logic [W-1:0] d, output int ew);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        ew           = cyc + 1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((m_act || mq.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        chk(name, 32'(n < 2000), 32'd1);
    endtask

    // Model update on every active edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_k   = 0;
            m_ovf = 1'b0;
        end else begin
            m_pop = (!m_act || m_k == WORD_CYC - 1) && (mq.size() > 0);
            if (m_act && m_k < WORD_CYC - 1) begin
                m_k++;
            end else if (m_pop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_k   = 0;
            end else begin
                m_act = 1'b0;
            end
            m_drop = 1'b0;
            if (bus.in_valid) begin
                if (mq.size() < DEP) mq.push_back(bus.in_data);
                else m_drop = 1'b1;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (bus.clr_ovf) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison and serial capture, away from the active edge.
    always @(negedge clk) begin
        e_bi = W - 1 - m_k / D;
        e_sd = m_act ? m_cur[e_bi] : 1'b0;
        chk("busy",     32'(bus.busy),     32'(m_act));
        chk("sdata",    32'(bus.sdata),    32'(e_sd));
        chk("sclk",     32'(bus.sclk),     32'(m_act && (m_k % D) >= H));
        chk("fs",       32'(bus.fs),       32'(m_act && m_k < D));
        chk("level",    32'(bus.level),    32'(mq.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (cyc < TR) begin
            fs_tr[cyc]   = bus.fs;
            busy_tr[cyc] = bus.busy;
            sclk_tr[cyc] = bus.sclk;
            lvl_tr[cyc]  = int'(bus.level);
        end
        if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
        if (bus.sclk === 1'b1 && sclk_prev !== 1'b1) begin
            rise_cnt++;
            if (bus.fs === 1'b1) cap_n = 0;
            cap = {cap[W-2:0], bus.sdata};
            cap_n++;
            if (cap_n == W) begin
                cap_q.push_back(cap);
                cap_n = 0;
            end
        end
        if (bus.fs === 1'b1 && fs_prev !== 1'b1) fs_rise.push_back(cyc);
        sclk_prev = bus.sclk;
        fs_prev   = bus.fs;
    end

    logic [W-1:0] ovf_exp [5];

    initial begin
        int ew;
        int ew2;
        int r0;
        int n;
        int ones;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clr_ovf  = 1'b0;
        rst          = 1'b1;
        repeat (3) tick();
        chk("reset_outputs",
            32'({bus.sclk, bus.sdata, bus.fs, bus.busy, bus.level, bus.overflow}), 32'd0);
        rst = 1'b0;
        tick();

        // Single word into an idle block.
        cap_q.delete();
        r0 = rise_cnt;
        wr(16'hA5C3, ew);
        drain("single_drain");
        chk("single_level_t1", 32'(lvl_tr[ew]), 32'd1);
        chk("single_fs_before", 32'(fs_tr[ew]), 32'd0);
        for (int i = 1; i <= 4; i++) chk("single_fs_high", 32'(fs_tr[ew + i]), 32'd1);
        chk("single_fs_after", 32'(fs_tr[ew + 5]), 32'd0);
        chk("single_sclk_low", 32'(sclk_tr[ew + 2]), 32'd0);
        chk("single_sclk_rise", 32'(sclk_tr[ew + 3]), 32'd1);
        chk("single_busy_last", 32'(busy_tr[ew + 64]), 32'd1);
        chk("single_busy_drop", 32'(busy_tr[ew + 65]), 32'd0);
        chk("single_rises", 32'(rise_cnt - r0), 32'd16);
        chk("single_count", 32'(cap_q.size()), 32'd1);
        chk("single_word", 32'(cap_q[0]), 32'hA5C3);

        // Reset in the middle of a word.
        wr(16'hA5C3, ew);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outputs",
            32'({bus.sclk, bus.sdata, bus.fs, bus.busy, bus.level, bus.overflow}), 32'd0);
        r0 = rise_cnt;
        repeat (30) tick();
        chk("midrst_no_sclk", 32'(rise_cnt - r0), 32'd0);
        chk("midrst_level", 32'(bus.level), 32'd0);

        // Back-to-back words.
        cap_q.delete();
        fs_rise.delete();
        wr(16'h8001, ew);
        wr(16'h7FFF, ew2);
        drain("b2b_drain");
        chk("b2b_fs_count", 32'(fs_rise.size()), 32'd2);
        chk("b2b_first_fs", 32'(fs_rise[0]), 32'(ew + 1));
        chk("b2b_fs_spacing", 32'(fs_rise[1] - fs_rise[0]), 32'd64);
        ones = 0;
        for (int i = 0; i < 128; i++) ones += int'(busy_tr[fs_rise[0] + i]);
        chk("b2b_no_gap", 32'(ones), 32'd128);
        chk("b2b_busy_end", 32'(busy_tr[fs_rise[0] + 128]), 32'd0);
        chk("b2b_words", 32'(cap_q.size()), 32'd2);
        chk("b2b_word0", 32'(cap_q[0]), 32'h8001);
        chk("b2b_word1", 32'(cap_q[1]), 32'h7FFF);

        // Overflow while the first word shifts.
        cap_q.delete();
        lvl_max = 0;
        wr(16'h1111, ew);
        tick();
        for (int i = 0; i < 6; i++) wr(16'h2000 + 16'(i), ew);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_level_peak", 32'(lvl_max), 32'd4);
        drain("ovf_drain");
        ovf_exp[0] = 16'h1111;
        for (int i = 0; i < 4; i++) ovf_exp[i + 1] = 16'h2000 + 16'(i);
        chk("ovf_words", 32'(cap_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("ovf_word", 32'(cap_q[i]), 32'(ovf_exp[i]));
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Write into a full FIFO on the end-of-word pop cycle, then set-beats-clear.
        cap_q.delete();
        wr(16'h3000, ew);
        tick();
        for (int i = 1; i <= 4; i++) wr(16'h3000 + 16'(i), ew);
        chk("full_level", 32'(bus.level), 32'd4);
        n = 0;
        while (!(m_act && m_k == WORD_CYC - 1) && n < 200) begin
            tick();
            n++;
        end
        chk("full_align", 32'(n < 200), 32'd1);
        wr(16'h3005, ew);
        chk("popwr_level", 32'(bus.level), 32'd4);
        chk("popwr_no_ovf", 32'(bus.overflow), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3006;
        bus.clr_ovf  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.clr_ovf  = 1'b0;
        chk("set_beats_clear", 32'(bus.overflow), 32'd1);
        drain("popwr_drain");
        chk("popwr_words", 32'(cap_q.size()), 32'd6);
        chk("popwr_first", 32'(cap_q[0]), 32'h3000);
        chk("popwr_last", 32'(cap_q[5]), 32'h3005);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;

        // Randomized traffic at increasing write densities.
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 800; i++) begin
                bus.in_valid = ($urandom_range(99) < 32'(2 + seg * 12));
                bus.in_data  = 16'($urandom);
                bus.clr_ovf  = ($urandom_range(99) < 3);
                rst          = ($urandom_range(999) < 2);
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.clr_ovf  = 1'b0;
        rst          = 1'b0;
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
